// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with status flags, a pass-through tag and
// valid/ready handshakes on the issue and result sides.
module alu_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_opcode,
    input  logic             in_signed,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_carry,
    output logic             out_ovf
);

    localparam int MSB = WIDTH - 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_GT  = 3'b010;
    localparam logic [2:0] OP_LT  = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_EQ  = 3'b111;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic [2:0]       s1_op_q, s1_op_d;
    logic             s1_signed_q, s1_signed_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_result_q, s2_result_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
    logic             s2_zero_q, s2_zero_d;
    logic             s2_neg_q, s2_neg_d;
    logic             s2_carry_q, s2_carry_d;
    logic             s2_ovf_q, s2_ovf_d;

    logic             s2_free, s1_free, s1_load, s2_load;
    logic [WIDTH:0]   sum, diff;
    logic             lt, gt;
    logic [WIDTH-1:0] res;
    logic             carry, ovf;

    assign s2_free  = !s2_valid_q || out_ready;
    assign s1_free  = !s1_valid_q || s2_free;
    assign s1_load  = in_valid && s1_free;
    assign s2_load  = s1_valid_q && s2_free;
    assign in_ready = s1_free;

    always_comb begin
        sum   = {1'b0, s1_a_q} + {1'b0, s1_b_q};
        diff  = {1'b0, s1_a_q} - {1'b0, s1_b_q};
        lt    = s1_signed_q ? ($signed(s1_a_q) < $signed(s1_b_q))
                            : (s1_a_q < s1_b_q);
        gt    = s1_signed_q ? ($signed(s1_a_q) > $signed(s1_b_q))
                            : (s1_a_q > s1_b_q);
        res   = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        unique case (s1_op_q)
            OP_ADD: begin
                res   = sum[MSB:0];
                carry = sum[WIDTH];
                ovf   = (s1_a_q[MSB] == s1_b_q[MSB]) &&
                        (sum[MSB] != s1_a_q[MSB]);
            end
            OP_SUB: begin
                // A borrow sets the extra bit, so carry is its inverse.
                res   = diff[MSB:0];
                carry = !diff[WIDTH];
                ovf   = (s1_a_q[MSB] != s1_b_q[MSB]) &&
                        (diff[MSB] != s1_a_q[MSB]);
            end
            OP_GT:  res = {{(WIDTH-1){1'b0}}, gt};
            OP_LT:  res = {{(WIDTH-1){1'b0}}, lt};
            OP_AND: res = s1_a_q & s1_b_q;
            OP_OR:  res = s1_a_q | s1_b_q;
            OP_XOR: res = s1_a_q ^ s1_b_q;
            OP_EQ:  res = {{(WIDTH-1){1'b0}}, s1_a_q == s1_b_q};
        endcase
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_op_d     = s1_op_q;
        s1_signed_d = s1_signed_q;
        s1_tag_d    = s1_tag_q;
        if (s2_load) begin
            s1_valid_d = 1'b0;
        end
        if (s1_load) begin
            s1_valid_d  = 1'b1;
            s1_a_d      = in_a;
            s1_b_d      = in_b;
            s1_op_d     = in_opcode;
            s1_signed_d = in_signed;
            s1_tag_d    = in_tag;
        end
    end

    always_comb begin
        s2_valid_d  = s2_load || (s2_valid_q && !out_ready);
        s2_result_d = s2_result_q;
        s2_tag_d    = s2_tag_q;
        s2_zero_d   = s2_zero_q;
        s2_neg_d    = s2_neg_q;
        s2_carry_d  = s2_carry_q;
        s2_ovf_d    = s2_ovf_q;
        if (s2_load) begin
            s2_result_d = res;
            s2_tag_d    = s1_tag_q;
            s2_zero_d   = (res == '0);
            s2_neg_d    = res[MSB];
            s2_carry_d  = carry;
            s2_ovf_d    = ovf;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_op_q     <= '0;
            s1_signed_q <= 1'b0;
            s1_tag_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_tag_q    <= '0;
            s2_zero_q   <= 1'b0;
            s2_neg_q    <= 1'b0;
            s2_carry_q  <= 1'b0;
            s2_ovf_q    <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_op_q     <= s1_op_d;
            s1_signed_q <= s1_signed_d;
            s1_tag_q    <= s1_tag_d;
            s2_valid_q  <= s2_valid_d;
            s2_result_q <= s2_result_d;
            s2_tag_q    <= s2_tag_d;
            s2_zero_q   <= s2_zero_d;
            s2_neg_q    <= s2_neg_d;
            s2_carry_q  <= s2_carry_d;
            s2_ovf_q    <= s2_ovf_d;
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_result = s2_result_q;
    assign out_tag    = s2_tag_q;
    assign out_zero   = s2_zero_q;
    assign out_neg    = s2_neg_q;
    assign out_carry  = s2_carry_q;
    assign out_ovf    = s2_ovf_q;

endmodule
